ternary_to_binary_converter: RTL and testbench

//   Sequential decoder from packed unsigned-ternary words to plain binary.

---
 rtl/ternary_to_binary_converter.sv | 125 ++++++++++++
 tb/tb_ternary_to_binary_converter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ternary_to_binary_converter.sv
// Sequential unsigned-ternary to binary decoder: one trit per cycle, MS trit first,
// acc = acc*3 + d, with valid/ready handshakes on input and output.
module ternary_to_binary_converter #(
    parameter int N     = 4,
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_trits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bin,
    output logic             out_err
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_q,     state_d;
    logic [2*N-1:0]     sreg_q,      sreg_d;
    logic [CW-1:0]      cnt_q,       cnt_d;
    logic [OUT_W-1:0]   acc_q,       acc_d;
    logic               err_q,       err_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_bin_q,   out_bin_d;
    logic               out_err_q,   out_err_d;

    logic [1:0]         digit;
    logic               illegal;
    logic [1:0]         digit_val;
    logic [OUT_W+1:0]   step;

    // Two extra bits hold acc*3+2 without wrap, so overflow is just the top bits.
    always_comb begin
        digit     = sreg_q[2*N-1 -: 2];
        illegal   = (digit == 2'b11);
        digit_val = illegal ? 2'b00 : digit;
        step      = ({2'b00, acc_q} * (OUT_W+2)'(3)) + (OUT_W+2)'(digit_val);
    end

    // NOTE: every *_d gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_err_d   = out_err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sreg_d     = in_trits;
                    acc_d      = '0;
                    err_d      = 1'b0;
                    cnt_d      = CW'(N);
                    in_ready_d = 1'b0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                acc_d  = step[OUT_W-1:0];
                err_d  = err_q | illegal | (|step[OUT_W+1:OUT_W]);
                sreg_d = {sreg_q[2*N-3:0], 2'b00};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_valid_d = 1'b1;
                    out_bin_d   = acc_d;
                    out_err_d   = err_d;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: all state uses non-blocking assignment and is cleared by the async reset;
    // there is no memory array here, so nothing is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ternary_to_binary_converter.sv
// Scoreboard bench: a 7-bit and a 6-bit converter share stimulus; expected
// results are pushed at accept time and popped by a monitor on output handshake.
module tb_ternary_to_binary_converter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_trits = 8'h00;
    logic       out_ready = 1'b1;

    logic       in_ready,  out_valid,  out_err;
    logic [6:0] out_bin;
    logic       in_ready6, out_valid6, out_err6;
    logic [5:0] out_bin6;

    ternary_to_binary_converter #(.N(N), .OUT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_trits(in_trits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_err(out_err)
    );

    ternary_to_binary_converter #(.N(N), .OUT_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready6), .in_trits(in_trits),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_bin(out_bin6), .out_err(out_err6)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic [6:0] bin7;
        logic       err7;
        logic [5:0] bin6;
        logic       err6;
        int         accept_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
                else check("latency", cyc - sb[0].accept_cyc, N);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("bin7_%h", e.word), {25'd0, out_bin}, {25'd0, e.bin7});
                check($sformatf("err7_%h", e.word), {31'd0, out_err}, {31'd0, e.err7});
                check($sformatf("valid6_%h", e.word), {31'd0, out_valid6}, 32'd1);
                check($sformatf("bin6_%h", e.word), {26'd0, out_bin6}, {26'd0, e.bin6});
                check($sformatf("err6_%h", e.word), {31'd0, out_err6}, {31'd0, e.err6});
            end
            prev_valid <= out_valid;
        end
    end

    task automatic send(input logic [7:0] w, input logic [6:0] b7, input logic e7,
                        input logic [5:0] b6, input logic e6, input bit push);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_trits = w;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{w, b7, e7, b6, e6, cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_bin"},   {25'd0, out_bin},   32'd0);
        check({tag, "_out_err"},   {31'd0, out_err},   32'd0);
        check({tag, "_out_bin6"},  {26'd0, out_bin6},  32'd0);
    endtask

    initial begin
        int n;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // word, bin7, err7, bin6, err6
        send(8'h46, 7'd32, 1'b0, 6'd32, 1'b0, 1'b1);  // 1,0,1,2
        send(8'hAA, 7'd80, 1'b0, 6'd16, 1'b1, 1'b1);  // 2222, overflows 6 bits
        send(8'h00, 7'd0,  1'b0, 6'd0,  1'b0, 1'b1);
        send(8'hC1, 7'd1,  1'b1, 6'd1,  1'b1, 1'b1);  // illegal MS trit
        send(8'h29, 7'd25, 1'b0, 6'd25, 1'b0, 1'b1);  // 0,2,2,1
        send(8'h9A, 7'd71, 1'b0, 6'd7,  1'b1, 1'b1);  // 2,1,2,2
        send(8'h8C, 7'd54, 1'b1, 6'd54, 1'b1, 1'b1);  // 2,0,illegal,0

        // Back-pressure: result must freeze while out_ready stays low.
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        #1;
        out_ready = 1'b0;
        send(8'h55, 7'd40, 1'b0, 6'd40, 1'b0, 1'b1);  // 1111
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_bin",   {25'd0, out_bin}, 32'd40);
            check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            in_valid = ~in_valid;
            in_trits = 8'(i * 37 + 5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        send(8'h46, 7'd32, 1'b0, 6'd32, 1'b0, 1'b1);

        // Reset two steps into CONV: abandoned word must never appear.
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        send(8'h55, 7'd40, 1'b0, 6'd40, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midconv_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hAA, 7'd80, 1'b0, 6'd16, 1'b1, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
